// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-wide Ram port between two requesters.
// Each transaction takes IDLE -> ACCESS -> RESP, with registered read data and a one-cycle ack.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              sel_we;

  assign sel_we = grant_q ? we1 : we0;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          grant_d = ~last_grant_q;
          state_d = ACCESS;
        end else if (req0) begin
          grant_d = 1'b0;
          state_d = ACCESS;
        end else if (req1) begin
          grant_d = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        last_grant_d = grant_q;
        if (!sel_we) begin
          if (grant_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
        end
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Port mux is gated by state so the idle requester never leaks onto the Ram bus
  always_comb begin
    mem_addr         = '0;
    mem_wdata        = '0;
    mem_write_enable = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr         = grant_q ? addr1  : addr0;
      mem_wdata        = grant_q ? wdata1 : wdata0;
      mem_write_enable = sel_we;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != IDLE);

endmodule
